// File: rtl/data_sram_bridge.sv
// Bridges the core's fixed-latency data SRAM port onto a split addr_ok/data_ok bus.
// Optional: define DSB_POSTED_WR_EN to retire writes on addr_ok (up to WBUF_DEPTH outstanding).
module data_sram_bridge #(
  parameter int unsigned WBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_mem,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e      state_q, state_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q, rdata_d;
  logic        req_load;
  logic        issue_ok;   // IDLE may accept the presented access this cycle
  logic        skip_resp;  // accepted request completes without a RESP phase
  logic        resp_held;  // a data_ok in RESP belongs to an earlier posted write

  // MEM does its own lane extraction, so reads always go out as full words.
  function automatic logic [1:0] size_of(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
      4'b0011, 4'b1100:                   size = 2'd1;
      default:                            size = 2'd2;
    endcase
    return size;
  endfunction

`ifdef DSB_POSTED_WR_EN
  localparam logic [2:0] WbufMax = 3'(WBUF_DEPTH);

  logic [2:0] wcnt_q, wcnt_d;
  logic       wr_accept;
  logic       wr_retire;

  assign wr_accept = (state_q == StReq) && wr_q && data_addr_ok;
  assign wr_retire = data_data_ok && (wcnt_q != 3'd0);

  always_comb begin
    wcnt_d = wcnt_q;
    if (wr_accept && !wr_retire) begin
      wcnt_d = wcnt_q + 3'd1;
    end else if (!wr_accept && wr_retire) begin
      wcnt_d = wcnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt_q <= 3'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  // Writes wait for a free slot; reads wait for every posted write to drain.
  assign issue_ok  = (|data_sram_wen) ? (wcnt_q != WbufMax) : (wcnt_q == 3'd0);
  assign skip_resp = wr_q;
  assign resp_held = (wcnt_q != 3'd0);
`else
  logic unused_wbuf_depth;
  assign unused_wbuf_depth = ^WBUF_DEPTH;

  assign issue_ok  = 1'b1;
  assign skip_resp = 1'b0;
  assign resp_held = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    req_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_sram_en && issue_ok) begin
          req_load = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (data_addr_ok) begin
          state_d = skip_resp ? StDone : StResp;
        end
      end
      StResp: begin
        if (data_data_ok && !resp_held) begin
          if (!wr_q) begin
            rdata_d = data_rdata;
          end
          state_d = StDone;
        end
      end
      // The core still presents the finished request here; it is not re-issued.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (req_load) begin
        wr_q    <= |data_sram_wen;
        size_q  <= size_of(data_sram_wen);
        addr_q  <= data_sram_addr;
        wdata_q <= data_sram_wdata;
        wstrb_q <= data_sram_wen;
      end
    end
  end

  assign data_req        = (state_q == StReq);
  assign data_wr         = wr_q;
  assign data_size       = size_q;
  assign data_addr       = addr_q;
  assign data_wstrb      = wstrb_q;
  assign data_wdata      = wdata_q;
  assign data_sram_rdata = rdata_q;
  assign stallreq_mem    = ((state_q == StIdle) && data_sram_en) ||
                           (state_q == StReq) || (state_q == StResp);

  // A pending request keeps its payload until the bus accepts it.
  req_stable_a: assert property (@(posedge clk) disable iff (!rst)
      data_req && !data_addr_ok |=>
      data_req && $stable({data_wr, data_size, data_addr, data_wstrb, data_wdata}));

endmodule
